// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch (I) and data (D) with D priority, I anti-starvation and timeout
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              i_err,
    output logic              d_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [SW-1:0]     r_starve_cnt;
    logic [TW-1:0]     r_tmo_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              w_starved;
    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_tmo;
    logic              w_busy_i;
    logic              w_busy_d;

    // I is forced only once D has won STARVE_LIMIT grants in a row while I waited
    assign w_starved = r_starve_cnt == SW'(STARVE_LIMIT);
    assign w_grant_d = d_req & !(i_req & w_starved);
    assign w_grant_i = !w_grant_d & i_req;
    assign w_tmo     = r_tmo_cnt == TW'(TIMEOUT);
    assign w_busy_i  = r_state == BUSY_I;
    assign w_busy_d  = r_state == BUSY_D;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // next state: registered grant from IDLE, return to IDLE on ack or timeout
    always_comb begin
        w_next = (r_state == IDLE) ? (w_grant_d ? BUSY_D : w_grant_i ? BUSY_I : IDLE)
               : (mem_ack | w_tmo) ? IDLE : r_state;
    end

    // request latches, starvation and timeout counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
        end else if (r_state == IDLE) begin
            r_tmo_cnt    <= '0;
            r_starve_cnt <= (w_grant_d & i_req) ? (w_starved ? r_starve_cnt : r_starve_cnt + SW'(1)) : '0;
            if (w_grant_d) begin
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
                r_we    <= d_we;
            end else if (w_grant_i) begin
                r_addr <= i_addr;
                r_we   <= 1'b0;
            end
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    // memory commands and completion pulses; ack wins over timeout on the same cycle
    always_comb begin
        mem_read  = w_busy_i | (w_busy_d & !r_we);
        mem_write = w_busy_d & r_we;
        i_ack     = w_busy_i & mem_ack;
        d_ack     = w_busy_d & mem_ack;
        i_err     = w_busy_i & !mem_ack & w_tmo;
        d_err     = w_busy_d & !mem_ack & w_tmo;
        i_rdata   = (w_busy_i & mem_ack) ? mem_rdata : '0;
        d_rdata   = (w_busy_d & mem_ack) ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic        i_err;
    logic        d_err;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [5:0]  exp_d_order;
    logic [15:0] exp_addr;

    mem_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .i_err(i_err), .d_err(d_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_iack"}, i_ack, 1'b0);
        chk1({tag, "_dack"}, d_ack, 1'b0);
        chk1({tag, "_ierr"}, i_err, 1'b0);
        chk1({tag, "_derr"}, d_err, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick();
        tick();
        #1;
        chk1("rst_rd", mem_read, 1'b0);
        chk1("rst_wr", mem_write, 1'b0);
        chk16("rst_addr", mem_addr, 16'h0000);
        chk16("rst_wdata", mem_wdata, 16'h0000);
        chk_quiet("rst");
        reset_n = 1'b1;
        // fetch only, ack on the 2nd busy cycle
        i_req = 1'b1; i_addr = 16'h0010;
        tick();
        mem_rdata = 16'hA5A5;
        #1;
        chk1("f_rd1", mem_read, 1'b1);
        chk1("f_wr1", mem_write, 1'b0);
        chk16("f_addr1", mem_addr, 16'h0010);
        chk1("f_ack1", i_ack, 1'b0);
        chk16("f_rdata_noack", i_rdata, 16'h0000);
        tick();
        mem_ack = 1'b1;
        #1;
        chk1("f_rd2", mem_read, 1'b1);
        chk16("f_addr2", mem_addr, 16'h0010);
        chk1("f_ack2", i_ack, 1'b1);
        chk16("f_rdata", i_rdata, 16'hA5A5);
        chk1("f_dack", d_ack, 1'b0);
        tick();
        mem_ack = 1'b0; i_req = 1'b0;
        #1;
        chk1("f_idle_rd", mem_read, 1'b0);
        chk_quiet("f_idle");
        // simultaneous requests: D store first, then one idle cycle, then I
        i_req = 1'b1; i_addr = 16'h0020;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
        tick();
        mem_ack = 1'b1;
        #1;
        chk1("s_wr", mem_write, 1'b1);
        chk1("s_rd", mem_read, 1'b0);
        chk16("s_addr", mem_addr, 16'h0040);
        chk16("s_wdata", mem_wdata, 16'h1234);
        chk1("s_dack", d_ack, 1'b1);
        chk1("s_iack", i_ack, 1'b0);
        tick();
        mem_ack = 1'b0; d_req = 1'b0;
        #1;
        chk1("s_gap_rd", mem_read, 1'b0);
        chk1("s_gap_wr", mem_write, 1'b0);
        chk_quiet("s_gap");
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h0F0F;
        #1;
        chk1("s_i_rd", mem_read, 1'b1);
        chk16("s_i_addr", mem_addr, 16'h0020);
        chk1("s_i_ack", i_ack, 1'b1);
        chk16("s_i_rdata", i_rdata, 16'h0F0F);
        tick();
        mem_ack = 1'b0; i_req = 1'b0;
        #1;
        chk1("s_end_rd", mem_read, 1'b0);
        // starvation: D,D,D then I forced, then D resumes
        exp_d_order = 6'b110111;
        i_req = 1'b1; i_addr = 16'h0030;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
        for (int k = 0; k < 6; k++) begin
            tick();
            mem_ack = 1'b1; mem_rdata = 16'h7700 + 16'(k);
            #1;
            exp_addr = exp_d_order[k] ? 16'h0050 : 16'h0030;
            chk16($sformatf("st_addr%0d", k), mem_addr, exp_addr);
            chk1($sformatf("st_dack%0d", k), d_ack, exp_d_order[k]);
            chk1($sformatf("st_iack%0d", k), i_ack, !exp_d_order[k]);
            tick();
            mem_ack = 1'b0;
            #1;
            chk1($sformatf("st_gap%0d", k), mem_read, 1'b0);
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
        // timeout on a D load: err on the 16th busy cycle
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0060;
        tick();
        #1;
        chk1("t_rd1", mem_read, 1'b1);
        chk1("t_err1", d_err, 1'b0);
        for (int c = 2; c <= 15; c++) tick();
        #1;
        chk1("t_err15", d_err, 1'b0);
        chk1("t_rd15", mem_read, 1'b1);
        tick();
        #1;
        chk1("t_err16", d_err, 1'b1);
        chk1("t_ack16", d_ack, 1'b0);
        chk1("t_ierr16", i_err, 1'b0);
        d_req = 1'b0;
        tick();
        mem_ack = 1'b1;
        #1;
        chk1("t_idle_rd", mem_read, 1'b0);
        chk_quiet("t_stray");
        tick();
        mem_ack = 1'b0;
        // ack exactly on the timeout cycle wins
        i_req = 1'b1; i_addr = 16'h0070;
        tick();
        for (int c = 2; c <= 16; c++) tick();
        mem_ack = 1'b1; mem_rdata = 16'h5A5A;
        #1;
        chk1("l_iack", i_ack, 1'b1);
        chk1("l_ierr", i_err, 1'b0);
        chk16("l_rdata", i_rdata, 16'h5A5A);
        tick();
        mem_ack = 1'b0; i_req = 1'b0;
        #1;
        chk1("l_idle_rd", mem_read, 1'b0);
        chk_quiet("l_idle");
        // reset mid-fetch, then a fresh fetch after release
        i_req = 1'b1; i_addr = 16'h0080;
        tick();
        #1;
        chk1("r_busy_rd", mem_read, 1'b1);
        reset_n = 1'b0;
        tick();
        mem_ack = 1'b1;
        #1;
        chk1("r_rd", mem_read, 1'b0);
        chk16("r_addr", mem_addr, 16'h0000);
        chk_quiet("r");
        reset_n = 1'b1; mem_ack = 1'b0;
        tick();
        #1;
        chk1("r_new_rd", mem_read, 1'b1);
        chk16("r_new_addr", mem_addr, 16'h0080);
        mem_ack = 1'b1;
        #1;
        chk1("r_new_ack", i_ack, 1'b1);
        tick();
        mem_ack = 1'b0; i_req = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
